lifo_arbiter: RTL and testbench

Shares one lifo instance (DWIDTH/AWIDTH stack with registered q_o, full/empty flags) between N_CLIENTS requesters. Each cycle it grants at most one push or pop request, round-robin. Pushes are gated by full and pops by empty, so the LIFO never sees an illegal request. Pop data is returned to the owning client one cycle later. A flush sequencer drains the stack on command.

---
 rtl/lifo_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/lifo_arbiter.sv | 153 +++++++++++++++
 tb/tb_lifo_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// lifo_arb_pkg
// Shared types and constants for the LIFO arbiter slice.
//   arb_state_e  : arbiter FSM states (ARB = normal arbitration, FLUSH = drain)
//   OP_PUSH/OP_POP : per-client op encoding on op_i
//   client_idx_t : client index wide enough for the largest supported client count
// ---------------------------------------------------------------------------
package lifo_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      FLUSH = 1'b1
   } arb_state_e;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   localparam int MAX_CLIENTS = 16;

   typedef logic [$clog2(MAX_CLIENTS)-1:0] client_idx_t;

endpackage : lifo_arb_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first asserted request found
// searching ptr, ptr+1, ... modulo N.
// Ports:
//   req         in  N  request vector
//   ptr         in  W  search start index (must be < N)
//   grant       out N  one-hot grant (0 when nothing requested)
//   grant_idx   out W  index of the granted request (0 when none)
//   grant_valid out 1  a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid
);

   // One spare bit so ptr + offset never overflows before the wrap.
   logic [W:0] cand;
   logic [W-1:0] cand_idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      cand_idx    = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (W+1)'(i);
         if (cand >= (W+1)'(N)) begin
            cand = cand - (W+1)'(N);
         end
         cand_idx = cand[W-1:0];
         if (!grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/lifo_arbiter.sv
// ---------------------------------------------------------------------------
// lifo_arbiter
// Shares one external LIFO between N_CLIENTS requesters. At most one push or
// pop is granted per cycle (round-robin); pushes are gated by full and pops
// by empty. Pop data returns to the owning client one cycle after accept.
// A flush command drains the stack, discarding the data.
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset
//   req_i/op_i/data_i      per-client request, op (1=push 0=pop), push data
//   ready_o                one-hot accept
//   rd_valid_o/rd_data_o   one-hot pop-return strobe, shared return data
//   flush_i                start drain (sampled in ARB only)
//   flush_busy_o/done_o    draining / one-cycle completion pulse
//   lifo_*                 connection to the LIFO (registered q, flags)
// ---------------------------------------------------------------------------
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int DWIDTH    = 16,
   parameter int AWIDTH    = 8,
   parameter int N_CLIENTS = 4
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic [N_CLIENTS-1:0]        req_i,
   input  logic [N_CLIENTS-1:0]        op_i,
   input  logic [N_CLIENTS*DWIDTH-1:0] data_i,
   output logic [N_CLIENTS-1:0]        ready_o,
   output logic [N_CLIENTS-1:0]        rd_valid_o,
   output logic [DWIDTH-1:0]           rd_data_o,
   input  logic                        flush_i,
   output logic                        flush_busy_o,
   output logic                        flush_done_o,
   output logic                        lifo_wrreq_o,
   output logic [DWIDTH-1:0]           lifo_data_o,
   output logic                        lifo_rdreq_o,
   input  logic [DWIDTH-1:0]           lifo_q_i,
   input  logic                        lifo_full_i,
   input  logic                        lifo_empty_i
);

   localparam int CWIDTH = $clog2(N_CLIENTS);

   arb_state_e          state_reg, state_next;
   logic [CWIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
   logic                pend_reg, pend_next;
   logic [CWIDTH-1:0]   owner_reg, owner_next;
   logic [DWIDTH-1:0]   rd_hold_reg, rd_hold_next;

   logic [DWIDTH-1:0]    client_data [N_CLIENTS];
   logic [N_CLIENTS-1:0] elig;
   logic [N_CLIENTS-1:0] grant;
   logic [CWIDTH-1:0]    grant_idx;
   logic                 grant_valid;
   logic                 grant_op;
   logic                 arb_active;

   // Arbitration only runs in ARB and never while reset is held, so every
   // output is quiet during reset even before the state register settles.
   assign arb_active = (state_reg == ARB) && !srst_i;

   generate
      for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
         assign client_data[gi] = data_i[gi*DWIDTH +: DWIDTH];
         assign elig[gi] = arb_active && req_i[gi] &&
                           ((op_i[gi] == OP_PUSH) ? !lifo_full_i : !lifo_empty_i);
         assign rd_valid_o[gi] = pend_reg && !srst_i && (owner_reg == CWIDTH'(gi));
      end
   endgenerate

   rr_arbiter #(
      .N (N_CLIENTS),
      .W (CWIDTH)
   ) u_rr (
      .req         (elig),
      .ptr         (rr_ptr_reg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign ready_o  = grant;
   assign grant_op = op_i[grant_idx];

   // The LIFO q is registered, so in the cycle after an accepted pop it
   // already holds the popped word; pass it straight through, then hold it.
   assign rd_data_o = pend_reg ? lifo_q_i : rd_hold_reg;

   always_comb begin
      state_next   = state_reg;
      rr_ptr_next  = rr_ptr_reg;
      pend_next    = 1'b0;
      owner_next   = owner_reg;
      rd_hold_next = pend_reg ? lifo_q_i : rd_hold_reg;
      lifo_wrreq_o = 1'b0;
      lifo_rdreq_o = 1'b0;
      lifo_data_o  = '0;
      flush_busy_o = 1'b0;
      flush_done_o = 1'b0;

      if (!srst_i) begin
         case (state_reg)
            ARB: begin
               if (grant_valid) begin
                  rr_ptr_next = (grant_idx == CWIDTH'(N_CLIENTS - 1)) ?
                                '0 : grant_idx + CWIDTH'(1);
                  if (grant_op == OP_PUSH) begin
                     lifo_wrreq_o = 1'b1;
                     lifo_data_o  = client_data[grant_idx];
                  end else begin
                     lifo_rdreq_o = 1'b1;
                     pend_next    = 1'b1;
                     owner_next   = grant_idx;
                  end
               end
               // A pop granted in this same cycle still gets its return.
               if (flush_i) begin
                  state_next = FLUSH;
               end
            end
            FLUSH: begin
               flush_busy_o = 1'b1;
               // Flags are exact with one op per cycle, so empty here means
               // nothing is left and no earlier pop is still in flight.
               if (!lifo_empty_i) begin
                  lifo_rdreq_o = 1'b1;
               end else begin
                  flush_done_o = 1'b1;
                  state_next   = ARB;
               end
            end
            default: state_next = ARB;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_reg   <= ARB;
         rr_ptr_reg  <= '0;
         pend_reg    <= 1'b0;
         owner_reg   <= '0;
         rd_hold_reg <= '0;
      end else begin
         state_reg   <= state_next;
         rr_ptr_reg  <= rr_ptr_next;
         pend_reg    <= pend_next;
         owner_reg   <= owner_next;
         rd_hold_reg <= rd_hold_next;
      end
   end

endmodule : lifo_arbiter

// File: tb/tb_lifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lifo_arbiter
// Directed bench for lifo_arbiter with a behavioural LIFO (registered q,
// flags derived from the entry count) attached to the lifo_* ports.
// ---------------------------------------------------------------------------
module tb_lifo_arbiter;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int NC = 4;
   localparam int DEPTH = 1 << AW;

   logic              clk_i_tb;
   logic              srst_i;
   logic [NC-1:0]     req_i;
   logic [NC-1:0]     op_i;
   logic [NC*DW-1:0]  data_i;
   logic [NC-1:0]     ready_o;
   logic [NC-1:0]     rd_valid_o;
   logic [DW-1:0]     rd_data_o;
   logic              flush_i;
   logic              flush_busy_o;
   logic              flush_done_o;
   logic              lifo_wrreq;
   logic [DW-1:0]     lifo_data;
   logic              lifo_rdreq;
   logic [DW-1:0]     lifo_q;
   logic              lifo_full;
   logic              lifo_empty;

   int n_checks = 0;
   int n_err    = 0;

   lifo_arbiter #(
      .DWIDTH    (DW),
      .AWIDTH    (AW),
      .N_CLIENTS (NC)
   ) dut (
      .clk_i        (clk_i_tb),
      .srst_i       (srst_i),
      .req_i        (req_i),
      .op_i         (op_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .rd_valid_o   (rd_valid_o),
      .rd_data_o    (rd_data_o),
      .flush_i      (flush_i),
      .flush_busy_o (flush_busy_o),
      .flush_done_o (flush_done_o),
      .lifo_wrreq_o (lifo_wrreq),
      .lifo_data_o  (lifo_data),
      .lifo_rdreq_o (lifo_rdreq),
      .lifo_q_i     (lifo_q),
      .lifo_full_i  (lifo_full),
      .lifo_empty_i (lifo_empty)
   );

   initial clk_i_tb = 1'b0;
   always #5 clk_i_tb = ~clk_i_tb;

   // Behavioural LIFO model
   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_m1;

   assign cnt_m1     = cnt - 1'b1;
   assign lifo_full  = (cnt == (AW+1)'(DEPTH));
   assign lifo_empty = (cnt == '0);

   always_ff @(posedge clk_i_tb) begin
      if (srst_i) begin
         cnt    <= '0;
         lifo_q <= '0;
      end else if (lifo_wrreq) begin
         mem[cnt[AW-1:0]] <= lifo_data;
         cnt              <= cnt + 1'b1;
      end else if (lifo_rdreq) begin
         lifo_q <= mem[cnt_m1[AW-1:0]];
         cnt    <= cnt_m1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i_tb);
      #1;
   endtask

   task automatic set_data(input int k, input logic [DW-1:0] v);
      data_i[k*DW +: DW] = v;
   endtask

   int rd_cnt, bad, done_cnt, grants;
   logic seen;

   initial begin
      srst_i  = 1'b1;
      req_i   = NC'($urandom);
      op_i    = NC'($urandom);
      data_i  = '0;
      flush_i = 1'b0;

      // ---- reset ----
      cyc();
      req_i = NC'($urandom);
      op_i  = NC'($urandom);
      #1;
      chk("rst_ready", 32'(ready_o), 32'h0);
      chk("rst_wrreq", 32'(lifo_wrreq), 32'h0);
      chk("rst_rdreq", 32'(lifo_rdreq), 32'h0);
      cyc();
      req_i = 4'hF;
      op_i  = NC'($urandom);
      #1;
      chk("rst_ready2", 32'(ready_o), 32'h0);
      chk("rst_rd_valid", 32'(rd_valid_o), 32'h0);
      chk("rst_rd_data", 32'(rd_data_o), 32'h0);
      chk("rst_busy", 32'(flush_busy_o), 32'h0);
      chk("rst_done", 32'(flush_done_o), 32'h0);
      $display("step reset: ready=%b rd_valid=%b", ready_o, rd_valid_o);

      // ---- fairness: all four push 0x1000+k ----
      cyc();
      srst_i = 1'b0;
      req_i  = 4'hF;
      op_i   = 4'hF;
      for (int k = 0; k < NC; k++) set_data(k, DW'(16'h1000 + k));
      #1;
      chk("fair_ready0", 32'(ready_o), 32'h1);
      chk("fair_wrreq0", 32'(lifo_wrreq), 32'h1);
      chk("fair_data0", 32'(lifo_data), 32'h1000);
      $display("step fair c0: ready=%b data=%h", ready_o, lifo_data);
      cyc(); #1;
      chk("fair_ready1", 32'(ready_o), 32'h2);
      cyc(); #1;
      chk("fair_ready2", 32'(ready_o), 32'h4);
      cyc(); #1;
      chk("fair_ready3", 32'(ready_o), 32'h8);
      chk("fair_data3", 32'(lifo_data), 32'h1003);
      $display("step fair c3: ready=%b data=%h", ready_o, lifo_data);

      // ---- pop by client 2 returns top of stack ----
      cyc();
      req_i = 4'b0100;
      op_i  = 4'b0000;
      #1;
      chk("pop_ready", 32'(ready_o), 32'h4);
      chk("pop_rdreq", 32'(lifo_rdreq), 32'h1);
      chk("pop_wrreq", 32'(lifo_wrreq), 32'h0);
      cyc();
      req_i = 4'b0000;
      #1;
      chk("pop_rd_valid", 32'(rd_valid_o), 32'h4);
      chk("pop_rd_data", 32'(rd_data_o), 32'h1003);
      $display("step pop c2: rd_valid=%b rd_data=%h", rd_valid_o, rd_data_o);
      cyc(); #1;
      chk("pop_rd_valid_off", 32'(rd_valid_o), 32'h0);
      chk("pop_rd_data_hold", 32'(rd_data_o), 32'h1003);

      // ---- fill to full: 3 entries present, 253 more by client 0 ----
      grants = 0;
      for (int i = 0; i < DEPTH - 3; i++) begin
         if (i > 0) cyc();
         req_i = 4'b0001;
         op_i  = 4'b0001;
         set_data(0, DW'(16'h2000 + i));
         #1;
         if (ready_o == 4'b0001 && lifo_wrreq) grants++;
      end
      chk("fill_grants", 32'(grants), 32'(DEPTH - 3));
      $display("step fill: grants=%0d", grants);
      cyc();
      req_i = 4'b0010;
      op_i  = 4'b0010;
      set_data(1, 16'h3111);
      #1;
      chk("full_push_ready", 32'(ready_o), 32'h0);
      chk("full_push_wrreq", 32'(lifo_wrreq), 32'h0);
      cyc();
      req_i = 4'b1010;
      #1;
      chk("full_pop_ready", 32'(ready_o), 32'h8);
      chk("full_pop_rdreq", 32'(lifo_rdreq), 32'h1);
      cyc();
      req_i = 4'b0010;
      #1;
      chk("full_rd_valid", 32'(rd_valid_o), 32'h8);
      chk("full_rd_data", 32'(rd_data_o), 32'h20FC);
      chk("full_push_late", 32'(ready_o), 32'h2);
      chk("full_push_data", 32'(lifo_data), 32'h3111);
      $display("step full: rd_data=%h ready=%b", rd_data_o, ready_o);
      cyc();
      req_i = 4'b0000;
      #1;
      chk("full_rd_valid_off", 32'(rd_valid_o), 32'h0);

      // ---- empty: clear with reset, client 0 pops for 20 cycles ----
      cyc();
      srst_i = 1'b1;
      cyc();
      srst_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) cyc();
         req_i = 4'b0001;
         op_i  = 4'b0000;
         #1;
         if (ready_o[0] || lifo_rdreq) bad++;
      end
      chk("empty_pop_blocked", 32'(bad), 32'h0);
      cyc();
      req_i = 4'b0011;
      op_i  = 4'b0010;
      set_data(1, 16'h4444);
      #1;
      chk("empty_push_ready", 32'(ready_o), 32'h2);
      chk("empty_push_data", 32'(lifo_data), 32'h4444);
      cyc();
      req_i = 4'b0001;
      op_i  = 4'b0000;
      #1;
      chk("empty_pop_ready", 32'(ready_o), 32'h1);
      cyc();
      req_i = 4'b0000;
      #1;
      chk("empty_rd_valid", 32'(rd_valid_o), 32'h1);
      chk("empty_rd_data", 32'(rd_data_o), 32'h4444);
      $display("step empty: rd_valid=%b rd_data=%h", rd_valid_o, rd_data_o);

      // ---- flush of 10 entries ----
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         req_i = 4'b0100;
         op_i  = 4'b0100;
         set_data(2, DW'(16'h5000 + i));
         #1;
         if (ready_o == 4'b0100) grants++;
      end
      chk("flush_fill", 32'(grants), 32'd10);
      cyc();
      req_i   = 4'b0000;
      flush_i = 1'b1;
      #1;
      chk("flush_entry_busy", 32'(flush_busy_o), 32'h0);
      cyc();
      flush_i = 1'b0;
      req_i   = 4'hF;
      op_i    = 4'b0101;
      set_data(0, 16'h6000);
      set_data(2, 16'h6002);
      #1;
      rd_cnt = 0; bad = 0; done_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (i > 0) begin cyc(); #1; end
         if (lifo_rdreq) rd_cnt++;
         if (ready_o != '0 || rd_valid_o != '0 || !flush_busy_o) bad++;
         if (flush_done_o) begin
            done_cnt++;
            seen = 1'b1;
         end
      end
      chk("flush_rdreq_count", 32'(rd_cnt), 32'd10);
      chk("flush_quiet", 32'(bad), 32'd0);
      chk("flush_done_count", 32'(done_cnt), 32'd1);
      $display("step flush: rdreq=%0d done=%0d", rd_cnt, done_cnt);
      cyc(); #1;
      chk("flush_resume_ready", 32'(ready_o), 32'h1);
      chk("flush_resume_busy", 32'(flush_busy_o), 32'h0);
      chk("flush_resume_done", 32'(flush_done_o), 32'h0);

      // ---- flush interrupted by reset after 5 pops ----
      cyc();
      req_i  = 4'b0000;
      srst_i = 1'b1;
      cyc();
      srst_i = 1'b0;
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         req_i = 4'b0010;
         op_i  = 4'b0010;
         set_data(1, DW'(16'h7000 + i));
         #1;
         if (ready_o == 4'b0010) grants++;
      end
      chk("rflush_fill", 32'(grants), 32'd10);
      cyc();
      req_i   = 4'b0000;
      flush_i = 1'b1;
      #1;
      cyc();
      flush_i = 1'b0;
      #1;
      rd_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 20 && rd_cnt < 5; i++) begin
         if (i > 0) begin cyc(); #1; end
         if (lifo_rdreq) rd_cnt++;
         if (flush_done_o) done_cnt++;
      end
      chk("rflush_rdreq_count", 32'(rd_cnt), 32'd5);
      cyc();
      srst_i = 1'b1;
      #1;
      chk("rflush_rst_done", 32'(flush_done_o), 32'h0);
      cyc();
      srst_i = 1'b0;
      #1;
      chk("rflush_busy_after", 32'(flush_busy_o), 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin cyc(); #1; end
         if (flush_done_o) done_cnt++;
      end
      chk("rflush_no_done", 32'(done_cnt), 32'd0);
      cyc();
      req_i = 4'b0100;
      op_i  = 4'b0100;
      #1;
      chk("rflush_arb_ready", 32'(ready_o), 32'h4);
      chk("rflush_rd_valid", 32'(rd_valid_o), 32'h0);
      $display("step reset-flush: ready=%b busy=%b", ready_o, flush_busy_o);
      cyc();
      req_i = 4'b0000;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_lifo_arbiter
